// File: rtl/fetch_stage_pipeline_if.sv
// Instruction memory bus between the fetch stage and a
// zero-latency instruction memory.
interface fetch_stage_pipeline_if #(
  parameter int ADDR_W  = 20,
  parameter int INSTR_W = 20
);
  logic [ADDR_W-1:0]  addr;
  logic [INSTR_W-1:0] instr;

  modport master (
    output addr,
    input  instr
  );

  modport slave (
    input  addr,
    output instr
  );
endinterface

// File: rtl/fetch_stage_pipeline.sv
// IF stage: program counter, imem address, IF/ID register,
// stall / redirect-with-flush / end-of-program handling.
module fetch_stage_pipeline #(
  parameter int                 ADDR_W   = 20,
  parameter int                 INSTR_W  = 20,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter logic [ADDR_W-1:0]  PC_MAX   = ADDR_W'(12),
  parameter logic [INSTR_W-1:0] NOP      = '0,
  parameter int                 CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  fetch_stage_pipeline_if.master imem,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0]  ifid_pc,
  output logic [ADDR_W-1:0]  ifid_pc_plus1,
  output logic               ifid_valid,
  output logic               end_of_prog,
  output logic [CNT_W-1:0]   fetch_count
);

  typedef enum logic [1:0] {
    ACT_REDIR,
    ACT_STALL,
    ACT_END,
    ACT_ADV
  } act_e;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_inc;
  logic              cnt_sat;
  act_e              act;

  assign imem.addr   = pc;
  assign pc_inc      = pc + ADDR_W'(1);
  assign end_of_prog = pc > PC_MAX;
  assign cnt_sat     = &fetch_count;

  // Redirect outranks stall so a resolved branch is never lost.
  always_comb begin
    act = ACT_ADV;
    priority case (1'b1)
      redirect_valid: act = ACT_REDIR;
      stall:          act = ACT_STALL;
      end_of_prog:    act = ACT_END;
      default:        act = ACT_ADV;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc            <= RESET_PC;
      ifid_instr    <= NOP;
      ifid_pc       <= '0;
      ifid_pc_plus1 <= '0;
      ifid_valid    <= 1'b0;
      fetch_count   <= '0;
    end else begin
      unique case (act)
        ACT_REDIR: begin
          pc         <= redirect_target;
          ifid_instr <= NOP;
          ifid_valid <= 1'b0;
        end
        ACT_STALL: begin
        end
        ACT_END: begin
          ifid_instr <= NOP;
          ifid_valid <= 1'b0;
        end
        ACT_ADV: begin
          pc            <= pc_inc;
          ifid_instr    <= imem.instr;
          ifid_pc       <= pc;
          ifid_pc_plus1 <= pc_inc;
          ifid_valid    <= 1'b1;
          if (!cnt_sat)
            fetch_count <= fetch_count + CNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage_pipeline.sv
// Bench for fetch_stage_pipeline: vector table, corner
// sequences and randomized run against a reference model.
module tb_fetch_stage_pipeline;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [19:0] redirect_target = '0;
  logic [19:0] ifid_instr, ifid_pc, ifid_pc_plus1;
  logic        ifid_valid, end_of_prog;
  logic [15:0] fetch_count;

  logic        stall_w = 1'b0;
  logic        redir_w = 1'b0;
  logic [19:0] target_w = '0;
  logic [19:0] w_instr, w_pc, w_pp1;
  logic        w_valid, w_eop;
  logic [15:0] w_cnt;

  int total = 0;
  int bad = 0;

  logic [19:0] m_pc, m_instr, m_ifpc, m_pp1;
  logic        m_valid;
  logic [15:0] m_cnt;

  always #5 clk = ~clk;

  function automatic logic [19:0] mem_f(logic [19:0] a);
    return (a * 20'd37) ^ 20'hA5A5B;
  endfunction

  fetch_stage_pipeline_if bus ();
  fetch_stage_pipeline_if bus_w ();
  assign bus.instr   = mem_f(bus.addr);
  assign bus_w.instr = mem_f(bus_w.addr);

  fetch_stage_pipeline dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .redirect_valid(redirect_valid),
    .redirect_target(redirect_target),
    .imem(bus), .ifid_instr(ifid_instr),
    .ifid_pc(ifid_pc), .ifid_pc_plus1(ifid_pc_plus1),
    .ifid_valid(ifid_valid), .end_of_prog(end_of_prog),
    .fetch_count(fetch_count)
  );

  fetch_stage_pipeline #(.PC_MAX(20'hFFFFF)) dut_w (
    .clk(clk), .rst_n(rst_n), .stall(stall_w),
    .redirect_valid(redir_w),
    .redirect_target(target_w),
    .imem(bus_w), .ifid_instr(w_instr),
    .ifid_pc(w_pc), .ifid_pc_plus1(w_pp1),
    .ifid_valid(w_valid), .end_of_prog(w_eop),
    .fetch_count(w_cnt)
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 20'd0; m_instr = 20'd0; m_ifpc = 20'd0;
    m_pp1 = 20'd0; m_valid = 1'b0; m_cnt = 16'd0;
  endtask

  task automatic model_edge();
    if (redirect_valid) begin
      m_pc = redirect_target;
      m_instr = 20'd0;
      m_valid = 1'b0;
    end else if (stall) begin
    end else if (m_pc > 20'd12) begin
      m_instr = 20'd0;
      m_valid = 1'b0;
    end else begin
      m_instr = mem_f(m_pc);
      m_ifpc = m_pc;
      m_pp1 = m_pc + 20'd1;
      m_valid = 1'b1;
      m_pc = m_pc + 20'd1;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
  endtask

  task automatic compare_all(string tag);
    chk({tag, ".instr"}, ifid_instr, m_instr);
    chk({tag, ".pc"}, ifid_pc, m_ifpc);
    chk({tag, ".pc1"}, ifid_pc_plus1, m_pp1);
    chk({tag, ".valid"}, ifid_valid, m_valid);
    chk({tag, ".cnt"}, fetch_count, m_cnt);
    chk({tag, ".addr"}, bus.addr, m_pc);
    chk({tag, ".eop"}, end_of_prog, m_pc > 20'd12);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        st;
    logic        rd;
    logic [19:0] tg;
    logic [19:0] instr;
    logic [19:0] pc;
    logic        valid;
    logic [15:0] cnt;
    logic [19:0] addr;
    logic        eop;
  } vec_t;

  function automatic vec_t mk(logic st, logic rd, logic [19:0] tg,
                              logic [19:0] instr, logic [19:0] pc,
                              logic valid, logic [15:0] cnt,
                              logic [19:0] addr, logic eop);
    vec_t v;
    v.st = st; v.rd = rd; v.tg = tg; v.instr = instr; v.pc = pc;
    v.valid = valid; v.cnt = cnt; v.addr = addr; v.eop = eop;
    return v;
  endfunction

  vec_t tbl[16];

  initial begin
    tbl[0]  = mk(0, 0, 0,  mem_f(0),  0,  1, 1, 1,  0);
    tbl[1]  = mk(0, 0, 0,  mem_f(1),  1,  1, 2, 2,  0);
    tbl[2]  = mk(1, 0, 0,  mem_f(1),  1,  1, 2, 2,  0);
    tbl[3]  = mk(1, 0, 0,  mem_f(1),  1,  1, 2, 2,  0);
    tbl[4]  = mk(1, 0, 0,  mem_f(1),  1,  1, 2, 2,  0);
    tbl[5]  = mk(0, 0, 0,  mem_f(2),  2,  1, 3, 3,  0);
    tbl[6]  = mk(0, 0, 0,  mem_f(3),  3,  1, 4, 4,  0);
    tbl[7]  = mk(1, 1, 9,  20'd0,     3,  0, 4, 9,  0);
    tbl[8]  = mk(0, 0, 0,  mem_f(9),  9,  1, 5, 10, 0);
    tbl[9]  = mk(0, 0, 0,  mem_f(10), 10, 1, 6, 11, 0);
    tbl[10] = mk(0, 0, 0,  mem_f(11), 11, 1, 7, 12, 0);
    tbl[11] = mk(0, 0, 0,  mem_f(12), 12, 1, 8, 13, 1);
    tbl[12] = mk(0, 0, 0,  20'd0,     12, 0, 8, 13, 1);
    tbl[13] = mk(0, 0, 0,  20'd0,     12, 0, 8, 13, 1);
    tbl[14] = mk(0, 1, 6,  20'd0,     12, 0, 8, 6,  0);
    tbl[15] = mk(0, 0, 0,  mem_f(6),  6,  1, 9, 7,  0);

    #2;
    model_reset();
    compare_all("por");
    do_reset();

    // table: fetch, stall, stall+redirect, end, redirect out of end
    for (int i = 0; i < 16; i++) begin
      stall = tbl[i].st;
      redirect_valid = tbl[i].rd;
      redirect_target = tbl[i].tg;
      step();
      chk($sformatf("tbl%0d.instr", i), ifid_instr, tbl[i].instr);
      chk($sformatf("tbl%0d.pc", i), ifid_pc, tbl[i].pc);
      chk($sformatf("tbl%0d.pc1", i), ifid_pc_plus1,
          tbl[i].pc + 20'd1);
      chk($sformatf("tbl%0d.valid", i), ifid_valid, tbl[i].valid);
      chk($sformatf("tbl%0d.cnt", i), fetch_count, tbl[i].cnt);
      chk($sformatf("tbl%0d.addr", i), bus.addr, tbl[i].addr);
      chk($sformatf("tbl%0d.eop", i), end_of_prog, tbl[i].eop);
    end
    stall = 0; redirect_valid = 0; redirect_target = 0;

    // straight run to end of program
    do_reset();
    for (int i = 0; i < 13; i++) step();
    chk("end.cnt", fetch_count, 16'd13);
    chk("end.eop", end_of_prog, 1'b1);
    chk("end.addr", bus.addr, 20'd13);
    chk("end.last", ifid_instr, mem_f(12));
    step();
    step();
    chk("end.bub_valid", ifid_valid, 1'b0);
    chk("end.bub_instr", ifid_instr, 20'd0);
    chk("end.hold_addr", bus.addr, 20'd13);
    chk("end.hold_cnt", fetch_count, 16'd13);
    redirect_valid = 1; redirect_target = 20'd6;
    step();
    redirect_valid = 0;
    step();
    chk("end.resume_instr", ifid_instr, mem_f(6));
    chk("end.resume_pc", ifid_pc, 20'd6);
    chk("end.resume_valid", ifid_valid, 1'b1);

    // wrap at top of address space (wide PC_MAX instance)
    do_reset();
    redir_w = 1; target_w = 20'hFFFFF;
    step();
    redir_w = 0;
    chk("wrap.addr_top", bus_w.addr, 20'hFFFFF);
    chk("wrap.eop_top", w_eop, 1'b0);
    step();
    chk("wrap.pc", w_pc, 20'hFFFFF);
    chk("wrap.pc1", w_pp1, 20'd0);
    chk("wrap.instr", w_instr, mem_f(20'hFFFFF));
    chk("wrap.addr", bus_w.addr, 20'd0);
    chk("wrap.valid", w_valid, 1'b1);

    // asynchronous reset between edges
    do_reset();
    for (int i = 0; i < 7; i++) step();
    chk("ar.pre_addr", bus.addr, 20'd7);
    chk("ar.pre_valid", ifid_valid, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("ar");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    compare_all("ar.restart");
    chk("ar.restart_pc", ifid_pc, 20'd0);

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      stall = ($urandom % 4) == 0;
      redirect_valid = ($urandom % 10) == 0;
      redirect_target = 20'($urandom_range(0, 15));
      step();
      compare_all($sformatf("rnd%0d", i));
    end
    stall = 0; redirect_valid = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
